stream_mux_rr: RTL
==================

STREAM_MUX_RR -- requirements
Module: stream_mux_rr

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data bits per channel.
REQ-002 SHALL have parameter N, default 8, number of input channels, legal range 2..16.
REQ-003 SHALL have localparam SELW = clog2(N), select/channel index width.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 SHALL have port in_valid  input  N  per-channel valid.
REQ-008 SHALL have port in_ready  output  N  per-channel ready, one-hot or zero.
REQ-009 SHALL have port mode  input  1  0 = FIXED (use sel), 1 = RR (round-robin).
REQ-010 SHALL have port sel  input  SELW  channel chosen in FIXED mode.
REQ-011 SHALL have port out_data  output  WIDTH  registered selected word.
REQ-012 SHALL have port out_valid  output  1  out_data holds an unconsumed word.
REQ-013 SHALL have port out_ready  input  1  downstream accepts out_data.
REQ-014 SHALL have port out_chan  output  SELW  index of the channel that supplied out_data.

Function
REQ-015 SHALL hold one output register stage; slot is "free" when out_valid=0, or when out_valid=1 and out_ready=1 in the same cycle.
REQ-016 SHALL transfer on input channel i only when in_valid[i]=1 and in_ready[i]=1; SHALL transfer on output only when out_valid=1 and out_ready=1.
REQ-017 SHALL assert in_ready[g] only for the granted channel g, only while the slot is free; in_ready SHALL be all zeros otherwise.
REQ-018 In FIXED mode, grant SHALL be g = sel when sel < N and in_valid[sel]=1; otherwise no grant.
REQ-019 In RR mode, grant SHALL be the first i with in_valid[i]=1, searching ptr, ptr+1, ..., wrapping modulo N; no grant if all invalid.
REQ-020 ptr SHALL update to (g+1) mod N only on an RR-mode input transfer; otherwise ptr SHALL hold, including throughout FIXED mode.
REQ-021 On input transfer, out_data SHALL load in_data channel g, out_chan SHALL load g, out_valid SHALL be 1 on the next cycle (latency 1 clock).
REQ-022 On output transfer with no simultaneous input transfer, out_valid SHALL go 0; out_data and out_chan SHALL hold their values.
REQ-023 While out_valid=1 and out_ready=0, out_data, out_chan and out_valid SHALL remain stable.
REQ-024 Simultaneous output and input transfer SHALL sustain one word per cycle with no bubble.
REQ-025 mode and sel SHALL be sampled combinationally each cycle; a change affects only the grant of that cycle, never a word already in the output register.
REQ-026 in_ready SHALL not depend combinationally on in_valid of non-granted channels beyond the grant search; out_ready is the only downstream-to-upstream combinational path.

Reset
REQ-027 While reset=1 at a rising edge: out_valid=0, out_data=0, out_chan=0, ptr=0.
REQ-028 During reset, in_ready SHALL be all zeros; a word in the output register mid-transfer SHALL be discarded.
REQ-029 First grant after reset deassertion in RR mode SHALL search from channel 0.

Structure
REQ-030 A shared package/header SHALL define MODE_FIXED=0 and MODE_RR=1 and the clog2 helper; no other shared typedefs.
REQ-031 Arbitration SHALL be one sub-module rr_arbiter (inputs: req[N], ptr; output: one-hot grant and encoded index), combinational; ptr register stays in stream_mux_rr.
REQ-032 Data selection SHALL be a parametric N-way WIDTH-bit selector driven by the encoded grant index.

Verification
REQ-033 Reset, then FIXED, sel=3, in_valid=8'h08, ch3=16'hBEEF, out_ready=1 -> next cycle out_valid=1, out_data=16'hBEEF, out_chan=3.
REQ-034 RR, in_valid=8'hFF constant, ch i=16'h0100+i, out_ready=1 -> out_chan sequence 0,1,...,7,0, one word per cycle.
REQ-035 RR, in_valid=8'h81, ptr=1 -> grant 7, then 0, then 7 (wrap).
REQ-036 out_valid=1, out_ready=0 for 3 cycles, inputs changing -> out_data/out_chan stable, in_ready=0; out_ready=1 -> next word loaded same edge.
REQ-037 FIXED, sel=5, in_valid[5]=0, others 1 -> no grant, in_ready=0, out_valid stays 0.
REQ-038 N=5, WIDTH=8 build, FIXED, sel=6 -> no grant; RR over in_valid=5'h1F -> out_chan 0..4 then 0.

Source files
------------

// File: rtl/stream_mux_rr_pkg.sv
// stream_mux_rr shared definitions.
// Mode encodings and the index-width helper.
package stream_mux_rr_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational rotating-priority arbiter.
// Searches ptr, ptr+1, ... modulo N for the first request.
module rr_arbiter
    import stream_mux_rr_pkg::*;
#(
    parameter int N = 8,
    localparam int SELW = clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [SELW-1:0] idx,
    output logic            any
);

    int c;

    // Walk offsets from far to near so the nearest request wins last.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        c   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            c = (int'(ptr) + k) % N;
            if (req[c[SELW-1:0]]) begin
                any = 1'b1;
                idx = c[SELW-1:0];
            end
        end
        if (any) gnt[idx] = 1'b1;
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel stream multiplexer with fixed or round-robin
// selection feeding a single registered output slot.
module stream_mux_rr
    import stream_mux_rr_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int N = 8,
    localparam int SELW = clog2(N)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SELW-1:0]      out_chan
);

    logic [SELW-1:0]  ptr;
    logic [SELW-1:0]  ptr_nxt;
    logic [N-1:0]     rr_gnt;
    logic [SELW-1:0]  rr_idx;
    logic             rr_any;
    logic             fixed_ok;
    logic             g_any;
    logic [SELW-1:0]  g_idx;
    logic             slot_free;
    logic             in_xfer;
    logic [WIDTH-1:0] sel_word;

    rr_arbiter #(
        .N(N)
    ) u_arb (
        .req(in_valid),
        .ptr(ptr),
        .gnt(rr_gnt),
        .idx(rr_idx),
        .any(rr_any)
    );

    always_comb begin
        fixed_ok = 1'b0;
        if (int'(sel) < N) fixed_ok = in_valid[sel];
        g_any = fixed_ok;
        g_idx = sel;
        if (mode == MODE_RR) begin
            g_any = rr_any;
            g_idx = rr_idx;
        end
    end

    assign slot_free = !out_valid || out_ready;
    assign in_xfer   = g_any && slot_free;

    always_comb begin
        in_ready = '0;
        if (in_xfer && !reset) in_ready[g_idx] = 1'b1;
    end

    always_comb begin
        sel_word = '0;
        for (int i = 0; i < N; i++) begin
            if (g_idx == SELW'(i)) sel_word = in_data[i*WIDTH +: WIDTH];
        end
    end

    assign ptr_nxt = (int'(g_idx) == N - 1) ? '0 : g_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            ptr       <= '0;
        end else begin
            if (in_xfer) begin
                out_valid <= 1'b1;
                out_data  <= sel_word;
                out_chan  <= g_idx;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            // Pointer only advances on RR transfers; FIXED traffic leaves it.
            if (in_xfer && mode == MODE_RR) ptr <= ptr_nxt;
        end
    end

    logic unused_ok;
    assign unused_ok = ^rr_gnt;

endmodule
